// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX->MEM pipeline register with stall/bubble/flush and MADD/MSUB feedback.
// Optional bubble counter (bubble_cnt_o) built only when EX_MEM_BUBBLE_CNT_EN is defined.
module ex_mem_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic            flush,
  input  logic [RW-1:0]   ex_wd,
  input  logic            ex_wreg,
  input  logic [DW-1:0]   ex_wdata,
  input  logic            ex_whilo,
  input  logic [DW-1:0]   ex_hi,
  input  logic [DW-1:0]   ex_lo,
  input  logic [7:0]      ex_aluop,
  input  logic [DW-1:0]   ex_mem_addr,
  input  logic [DW-1:0]   ex_reg2,
  input  logic            ex_cp0_we,
  input  logic [RW-1:0]   ex_cp0_waddr,
  input  logic [DW-1:0]   ex_cp0_data,
  input  logic [DW-1:0]   ex_excepttype,
  input  logic [DW-1:0]   ex_inst_addr,
  input  logic            ex_is_in_delayslot,
  input  logic [2*DW-1:0] hilo_temp_i,
  input  logic [1:0]      cnt_i,
  output logic [RW-1:0]   mem_wd,
  output logic            mem_wreg,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_whilo,
  output logic [DW-1:0]   mem_hi,
  output logic [DW-1:0]   mem_lo,
  output logic [7:0]      mem_aluop,
  output logic [DW-1:0]   mem_mem_addr,
  output logic [DW-1:0]   mem_reg2,
  output logic            mem_cp0_we,
  output logic [RW-1:0]   mem_cp0_waddr,
  output logic [DW-1:0]   mem_cp0_data,
  output logic [DW-1:0]   mem_excepttype,
  output logic [DW-1:0]   mem_inst_addr,
  output logic            mem_is_in_delayslot,
  output logic [2*DW-1:0] hilo_temp_o,
  output logic [1:0]      cnt_o
`ifdef EX_MEM_BUBBLE_CNT_EN
  ,
  output logic [31:0]     bubble_cnt_o
`endif
);

  logic [RW-1:0]   wd_q, wd_d;
  logic            wreg_q, wreg_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            whilo_q, whilo_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [7:0]      aluop_q, aluop_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   reg2_q, reg2_d;
  logic            cp0_we_q, cp0_we_d;
  logic [RW-1:0]   cp0_waddr_q, cp0_waddr_d;
  logic [DW-1:0]   cp0_data_q, cp0_data_d;
  logic [DW-1:0]   excepttype_q, excepttype_d;
  logic [DW-1:0]   inst_addr_q, inst_addr_d;
  logic            delayslot_q, delayslot_d;
  logic [2*DW-1:0] hilo_temp_q, hilo_temp_d;
  logic [1:0]      cnt_q, cnt_d;

  logic do_bubble;
  logic do_advance;

  // stall[3]=0 with stall[4]=1 cannot come from ctrl; it simply falls into advance.
  assign do_bubble  = !flush && stall[3] && !stall[4];
  assign do_advance = !flush && !stall[3];

  always_comb begin
    wd_d         = wd_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    whilo_d      = whilo_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    aluop_d      = aluop_q;
    mem_addr_d   = mem_addr_q;
    reg2_d       = reg2_q;
    cp0_we_d     = cp0_we_q;
    cp0_waddr_d  = cp0_waddr_q;
    cp0_data_d   = cp0_data_q;
    excepttype_d = excepttype_q;
    inst_addr_d  = inst_addr_q;
    delayslot_d  = delayslot_q;
    hilo_temp_d  = hilo_temp_q;
    cnt_d        = cnt_q;
    if (flush || do_bubble) begin
      wd_d         = '0;
      wreg_d       = 1'b0;
      wdata_d      = '0;
      whilo_d      = 1'b0;
      hi_d         = '0;
      lo_d         = '0;
      aluop_d      = 8'h00;
      mem_addr_d   = '0;
      reg2_d       = '0;
      cp0_we_d     = 1'b0;
      cp0_waddr_d  = '0;
      cp0_data_d   = '0;
      excepttype_d = '0;
      inst_addr_d  = '0;
      delayslot_d  = 1'b0;
      // A bubble must preserve the multi-cycle MADD/MSUB state; a flush discards it.
      hilo_temp_d  = do_bubble ? hilo_temp_i : '0;
      cnt_d        = do_bubble ? cnt_i : 2'd0;
    end else if (do_advance) begin
      wd_d         = ex_wd;
      wreg_d       = ex_wreg;
      wdata_d      = ex_wdata;
      whilo_d      = ex_whilo;
      hi_d         = ex_hi;
      lo_d         = ex_lo;
      aluop_d      = ex_aluop;
      mem_addr_d   = ex_mem_addr;
      reg2_d       = ex_reg2;
      cp0_we_d     = ex_cp0_we;
      cp0_waddr_d  = ex_cp0_waddr;
      cp0_data_d   = ex_cp0_data;
      excepttype_d = ex_excepttype;
      inst_addr_d  = ex_inst_addr;
      delayslot_d  = ex_is_in_delayslot;
      hilo_temp_d  = '0;
      cnt_d        = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q         <= '0;
      wreg_q       <= 1'b0;
      wdata_q      <= '0;
      whilo_q      <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      aluop_q      <= 8'h00;
      mem_addr_q   <= '0;
      reg2_q       <= '0;
      cp0_we_q     <= 1'b0;
      cp0_waddr_q  <= '0;
      cp0_data_q   <= '0;
      excepttype_q <= '0;
      inst_addr_q  <= '0;
      delayslot_q  <= 1'b0;
      hilo_temp_q  <= '0;
      cnt_q        <= 2'd0;
    end else begin
      wd_q         <= wd_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      whilo_q      <= whilo_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      aluop_q      <= aluop_d;
      mem_addr_q   <= mem_addr_d;
      reg2_q       <= reg2_d;
      cp0_we_q     <= cp0_we_d;
      cp0_waddr_q  <= cp0_waddr_d;
      cp0_data_q   <= cp0_data_d;
      excepttype_q <= excepttype_d;
      inst_addr_q  <= inst_addr_d;
      delayslot_q  <= delayslot_d;
      hilo_temp_q  <= hilo_temp_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_wd              = wd_q;
  assign mem_wreg            = wreg_q;
  assign mem_wdata           = wdata_q;
  assign mem_whilo           = whilo_q;
  assign mem_hi              = hi_q;
  assign mem_lo              = lo_q;
  assign mem_aluop           = aluop_q;
  assign mem_mem_addr        = mem_addr_q;
  assign mem_reg2            = reg2_q;
  assign mem_cp0_we          = cp0_we_q;
  assign mem_cp0_waddr       = cp0_waddr_q;
  assign mem_cp0_data        = cp0_data_q;
  assign mem_excepttype      = excepttype_q;
  assign mem_inst_addr       = inst_addr_q;
  assign mem_is_in_delayslot = delayslot_q;
  assign hilo_temp_o         = hilo_temp_q;
  assign cnt_o               = cnt_q;

`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (do_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - directed self-checking bench for ex_mem_reg.
// Bubble-counter steps are built only when EX_MEM_BUBBLE_CNT_EN is defined.
module tb_ex_mem_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'd0;
  logic        flush = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = '0, ex_lo = '0;
  logic [7:0]  ex_aluop = '0;
  logic [31:0] ex_mem_addr = '0, ex_reg2 = '0;
  logic        ex_cp0_we = 1'b0;
  logic [4:0]  ex_cp0_waddr = '0;
  logic [31:0] ex_cp0_data = '0, ex_excepttype = '0, ex_inst_addr = '0;
  logic        ex_is_in_delayslot = 1'b0;
  logic [63:0] hilo_temp_i = '0;
  logic [1:0]  cnt_i = '0;

  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic        mem_cp0_we;
  logic [4:0]  mem_cp0_waddr;
  logic [31:0] mem_cp0_data, mem_excepttype, mem_inst_addr;
  logic        mem_is_in_delayslot;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_o;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .ex_cp0_we(ex_cp0_we), .ex_cp0_waddr(ex_cp0_waddr),
    .ex_cp0_data(ex_cp0_data), .ex_excepttype(ex_excepttype), .ex_inst_addr(ex_inst_addr),
    .ex_is_in_delayslot(ex_is_in_delayslot), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .mem_cp0_we(mem_cp0_we), .mem_cp0_waddr(mem_cp0_waddr),
    .mem_cp0_data(mem_cp0_data), .mem_excepttype(mem_excepttype), .mem_inst_addr(mem_inst_addr),
    .mem_is_in_delayslot(mem_is_in_delayslot), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
`ifdef EX_MEM_BUBBLE_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ex();
    ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hA5A5_0001; ex_whilo = 1'b1;
    ex_hi = 32'h1111; ex_lo = 32'h2222; ex_aluop = 8'h23; ex_mem_addr = 32'h8000_0010;
    ex_reg2 = 32'h3333; ex_cp0_we = 1'b1; ex_cp0_waddr = 5'd12; ex_cp0_data = 32'h4444;
    ex_excepttype = 32'h100; ex_inst_addr = 32'hBFC0_0000; ex_is_in_delayslot = 1'b1;
  endtask

  initial begin
    #1;
    check("reset_wdata", {32'd0, mem_wdata}, 64'd0);
    check("reset_aluop", {56'd0, mem_aluop}, 64'd0);
    check("reset_hilo", hilo_temp_o, 64'd0);
    tick();
    rst = 1'b0;

    // all fields advance, including those not named in the directed step
    load_ex();
    tick();
    check("adv_all_wd", {59'd0, mem_wd}, 64'd7);
    check("adv_all_aluop", {56'd0, mem_aluop}, 64'h23);
    check("adv_all_cp0", {27'd0, mem_cp0_waddr, mem_cp0_data}, {27'd0, 5'd12, 32'h4444});
    check("adv_all_misc", {mem_inst_addr, mem_excepttype},
          {32'hBFC0_0000, 32'h100});
    check("adv_all_bits", {59'd0, mem_wreg, mem_whilo, mem_cp0_we, mem_is_in_delayslot, 1'b0},
          {59'd0, 5'b11110});
    check("adv_all_hilo", {mem_hi, mem_lo}, {32'h1111, 32'h2222});
    check("adv_all_addr", {mem_mem_addr, mem_reg2}, {32'h8000_0010, 32'h3333});

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_rst_wdata", {32'd0, mem_wdata}, 64'd0);
    check("async_rst_wreg", {63'd0, mem_wreg}, 64'd0);
    check("async_rst_inst", {32'd0, mem_inst_addr}, 64'd0);
    rst = 1'b0;
    tick();

    // directed advance
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; stall = 6'd0;
    tick();
    check("adv_wd", {59'd0, mem_wd}, 64'd3);
    check("adv_wreg", {63'd0, mem_wreg}, 64'd1);
    check("adv_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);

    // bubble for two cycles
    ex_aluop = 8'h23;
    stall = 6'b001111; hilo_temp_i = 64'h1_0000_0002; cnt_i = 2'd1;
    tick();
    check("bub1_wreg", {63'd0, mem_wreg}, 64'd0);
    check("bub1_aluop", {56'd0, mem_aluop}, 64'd0);
    check("bub1_hilo", hilo_temp_o, 64'h1_0000_0002);
    check("bub1_cnt", {62'd0, cnt_o}, 64'd1);
    tick();
    check("bub2_wreg", {63'd0, mem_wreg}, 64'd0);
    check("bub2_aluop", {56'd0, mem_aluop}, 64'd0);
    check("bub2_hilo", hilo_temp_o, 64'h1_0000_0002);
    check("bub2_cnt", {62'd0, cnt_o}, 64'd1);

    // advance clears the MADD/MSUB feedback
    stall = 6'd0; ex_wdata = 32'h1234;
    tick();
    check("adv_clr_hilo", hilo_temp_o, 64'd0);
    check("adv_clr_cnt", {62'd0, cnt_o}, 64'd0);
    check("adv_wdata_1234", {32'd0, mem_wdata}, 64'h1234);

    // hold for three cycles while inputs change
    stall = 6'b011111; ex_wdata = 32'hFFFF_0000; hilo_temp_i = 64'h55; cnt_i = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_wdata_%0d", i), {32'd0, mem_wdata}, 64'h1234);
      check($sformatf("hold_cnt_%0d", i), {62'd0, cnt_o}, 64'd0);
    end

    // load feedback state via a bubble, then flush under a hold stall
    stall = 6'b001111; cnt_i = 2'd3;
    tick();
    check("pre_flush_cnt", {62'd0, cnt_o}, 64'd3);
    flush = 1'b1; stall = 6'b011111; ex_excepttype = 32'h200;
    tick();
    check("flush_except", {32'd0, mem_excepttype}, 64'd0);
    check("flush_cnt", {62'd0, cnt_o}, 64'd0);
    check("flush_hilo", hilo_temp_o, 64'd0);
    flush = 1'b0;

    // illegal stall[3]=0, stall[4]=1 behaves as advance
    stall = 6'b010111; ex_wdata = 32'hCAFE_0001;
    tick();
    check("illegal_adv", {32'd0, mem_wdata}, 64'hCAFE_0001);
    stall = 6'd0;

`ifdef EX_MEM_BUBBLE_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("bcnt_reset", {32'd0, bubble_cnt_o}, 64'd0);
    stall = 6'b001111;
    for (int i = 0; i < 4; i++) begin
      flush = (i == 2);
      tick();
    end
    flush = 1'b0;
    check("bcnt_flush", {32'd0, bubble_cnt_o}, 64'd3);
    stall = 6'd0;
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt_q;
    stall = 6'b001111;
    tick();
    check("bcnt_sat", {32'd0, bubble_cnt_o}, 64'hFFFF_FFFF);
    stall = 6'd0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
